slow_bcd_counter: RTL



---
 rtl/slow_bcd_counter.sv | 78 +++++++
 1 files changed

// File: rtl/slow_bcd_counter.sv
// Multi-digit slow BCD counter: up/down, parallel load with per-digit clamp, soft clear,
// wrap or saturate at terminal count, combinational carry-out and sticky overflow.
module slow_bcd_counter #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned MAX_DIGIT  = 9,
    parameter bit          SATURATE   = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    slowena,
    input  logic                    up_dn,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] q,
    output logic                    carry_out,
    output logic                    overflow
);

    localparam logic [3:0] MaxD = 4'(MAX_DIGIT);

    logic [4*NUM_DIGITS-1:0] step_val;
    logic [4*NUM_DIGITS-1:0] load_clamped;
    logic                    terminal;
    logic                    ripple;

    // Ripple carry/borrow through the digits; a digit only moves when all lower digits are at
    // their rollover value, and the final ripple is the terminal-count condition.
    always_comb begin
        step_val = q;
        ripple   = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (up_dn) begin
                if (ripple) begin
                    step_val[4*k +: 4] = (q[4*k +: 4] == MaxD) ? 4'd0 : q[4*k +: 4] + 4'd1;
                end
                ripple = ripple & (q[4*k +: 4] == MaxD);
            end else begin
                if (ripple) begin
                    step_val[4*k +: 4] = (q[4*k +: 4] == 4'd0) ? MaxD : q[4*k +: 4] - 4'd1;
                end
                ripple = ripple & (q[4*k +: 4] == 4'd0);
            end
        end
        terminal = ripple;
    end

    always_comb begin
        load_clamped = load_val;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (load_val[4*k +: 4] > MaxD) begin
                load_clamped[4*k +: 4] = MaxD;
            end
        end
    end

    assign carry_out = slowena & reset & ~clear & ~load & terminal;

    always_ff @(posedge clk) begin
        if (!reset) begin
            q        <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            q        <= '0;
            overflow <= 1'b0;
        end else if (load) begin
            q <= load_clamped;
        end else if (slowena) begin
            if (terminal) begin
                overflow <= 1'b1;
            end
            if (!(SATURATE && terminal)) begin
                q <= step_val;
            end
        end
    end

endmodule
